// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bundle for ex_muldiv_unit: operand sources, issue handshake, result handshake.
interface ex_muldiv_unit_if #(
  parameter int unsigned NB_WORD = 32
);
  logic               i_valid;
  logic               o_ready;
  logic               i_is_m;
  logic [2:0]         i_op;
  logic               i_arith_logic;
  logic               i_alu_src1;
  logic               i_alu_src2;
  logic [1:0]         i_forward_rs1;
  logic [1:0]         i_forward_rs2;
  logic [NB_WORD-1:0] i_op1;
  logic [NB_WORD-1:0] i_op2;
  logic [NB_WORD-1:0] i_immediate;
  logic [NB_WORD-1:0] i_pc;
  logic [NB_WORD-1:0] i_ex_mem_res;
  logic [NB_WORD-1:0] i_wb_res;
  logic               i_flush;
  logic               o_valid;
  logic               i_ready;
  logic [NB_WORD-1:0] o_result;
  logic               o_busy;

  modport master (
    output i_valid, i_is_m, i_op, i_arith_logic, i_alu_src1, i_alu_src2, i_forward_rs1,
           i_forward_rs2, i_op1, i_op2, i_immediate, i_pc, i_ex_mem_res, i_wb_res, i_flush,
           i_ready,
    input  o_ready, o_valid, o_result, o_busy
  );

  modport slave (
    input  i_valid, i_is_m, i_op, i_arith_logic, i_alu_src1, i_alu_src2, i_forward_rs1,
           i_forward_rs2, i_op1, i_op2, i_immediate, i_pc, i_ex_mem_res, i_wb_res, i_flush,
           i_ready,
    output o_ready, o_valid, o_result, o_busy
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Execute unit: single-cycle base ALU plus iterative RV32M multiply (shift-add) and
// restoring divide, both working on magnitudes with sign fix-up on the final iteration.
module ex_muldiv_unit #(
  parameter int unsigned NB_WORD = 32,
  parameter int unsigned NB_CNT  = $clog2(NB_WORD) + 1
) (
  input logic             i_clock,
  input logic             i_reset,
  ex_muldiv_unit_if.slave bus
);
  localparam int unsigned NbSh = $clog2(NB_WORD);
  localparam logic [NB_WORD-1:0] MinNeg = {1'b1, {(NB_WORD-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e                 state_q, state_d;
  logic [NB_CNT-1:0]      cnt_q, cnt_d;
  logic [2*NB_WORD-1:0]   acc_q, acc_d;
  logic [NB_WORD-1:0]     b_q, b_d;
  logic                   neg_q, neg_d, hi_q, hi_d, div_q, div_d, valid_q, valid_d;
  logic [NB_WORD-1:0]     result_q, result_d;

  logic [NB_WORD-1:0]     op_a, op_b, alu_res, mag_a, mag_b, fin_val, fin_res;
  logic [NbSh-1:0]        shamt;
  logic                   accept, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [NB_WORD:0]       mul_sum, rem_sh, rem_diff;
  logic [2*NB_WORD-1:0]   step_acc, prod_fix;

  assign bus.o_ready  = (state_q == StIdle) && (!valid_q || bus.i_ready);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_busy   = (state_q == StMul) || (state_q == StDiv);
  assign accept       = bus.i_valid && bus.o_ready && !bus.i_flush;

  always_comb begin
    if (bus.i_alu_src1)               op_a = bus.i_pc;
    else if (bus.i_forward_rs1 == 2'b10) op_a = bus.i_ex_mem_res;
    else if (bus.i_forward_rs1 == 2'b01) op_a = bus.i_wb_res;
    else                              op_a = bus.i_op1;
    if (bus.i_alu_src2)               op_b = bus.i_immediate;
    else if (bus.i_forward_rs2 == 2'b10) op_b = bus.i_ex_mem_res;
    else if (bus.i_forward_rs2 == 2'b01) op_b = bus.i_wb_res;
    else                              op_b = bus.i_op2;
  end

  assign shamt = op_b[NbSh-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.i_op)
      3'b000:  alu_res = bus.i_arith_logic ? op_a - op_b : op_a + op_b;
      3'b001:  alu_res = op_a << shamt;
      3'b010:  alu_res = {{(NB_WORD-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011:  alu_res = {{(NB_WORD-1){1'b0}}, (op_a < op_b)};
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = bus.i_arith_logic ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
      3'b110:  alu_res = op_a | op_b;
      default: alu_res = op_a & op_b;
    endcase
  end

  // Signedness per M op: divides are signed for DIV/REM; MULH both, MULHSU only rs1.
  always_comb begin
    a_sgn    = bus.i_op[2] ? !bus.i_op[0] : (bus.i_op[1:0] == 2'b01 || bus.i_op[1:0] == 2'b10);
    b_sgn    = bus.i_op[2] ? !bus.i_op[0] : (bus.i_op[1:0] == 2'b01);
    a_neg    = a_sgn && op_a[NB_WORD-1];
    b_neg    = b_sgn && op_b[NB_WORD-1];
    mag_a    = a_neg ? -op_a : op_a;
    mag_b    = b_neg ? -op_b : op_b;
    div_zero = (op_b == '0);
    div_ovf  = a_sgn && (op_a == MinNeg) && (op_b == '1);
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*NB_WORD-1:NB_WORD]} + {1'b0, (acc_q[0] ? b_q : '0)};
    rem_sh   = {acc_q[2*NB_WORD-1:NB_WORD], acc_q[NB_WORD-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    if (div_q) begin
      step_acc = rem_diff[NB_WORD] ? {rem_sh[NB_WORD-1:0], acc_q[NB_WORD-2:0], 1'b0}
                                   : {rem_diff[NB_WORD-1:0], acc_q[NB_WORD-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc_q[NB_WORD-1:1]};
    end
    prod_fix = neg_q ? -step_acc : step_acc;
    fin_val  = hi_q ? step_acc[2*NB_WORD-1:NB_WORD] : step_acc[NB_WORD-1:0];
    if (div_q) fin_res = neg_q ? -fin_val : fin_val;
    else       fin_res = hi_q ? prod_fix[2*NB_WORD-1:NB_WORD] : prod_fix[NB_WORD-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    div_d    = div_q;
    valid_d  = valid_q;
    result_d = result_q;
    if (valid_q && bus.i_ready) valid_d = 1'b0;
    if (bus.i_flush) begin
      state_d = StIdle;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            if (!bus.i_is_m) begin
              valid_d  = 1'b1;
              result_d = alu_res;
            end else if (bus.i_op[2] && div_zero) begin
              valid_d  = 1'b1;
              result_d = bus.i_op[1] ? op_a : '1;
            end else if (bus.i_op[2] && div_ovf) begin
              valid_d  = 1'b1;
              result_d = bus.i_op[1] ? '0 : MinNeg;
            end else begin
              state_d = bus.i_op[2] ? StDiv : StMul;
              div_d   = bus.i_op[2];
              hi_d    = bus.i_op[2] ? bus.i_op[1] : (bus.i_op[1:0] != 2'b00);
              neg_d   = (bus.i_op[2] && bus.i_op[1]) ? a_neg : (a_neg ^ b_neg);
              acc_d   = {{NB_WORD{1'b0}}, (bus.i_op[2] ? mag_a : mag_b)};
              b_d     = bus.i_op[2] ? mag_b : mag_a;
            end
          end
        end
        StMul, StDiv: begin
          acc_d = step_acc;
          cnt_d = cnt_q + NB_CNT'(1);
          if (cnt_q == NB_CNT'(NB_WORD - 1)) begin
            state_d  = StDone;
            cnt_d    = '0;
            valid_d  = 1'b1;
            result_d = fin_res;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      div_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      div_q    <= div_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomised self-checking bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
  localparam int unsigned NW = 32;
  localparam logic [31:0] MinNeg = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.NB_WORD(NW)) bus ();
  ex_muldiv_unit #(.NB_WORD(NW)) dut (.i_clock(clk), .i_reset(rst), .bus(bus));

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = a;
    longint ub = b;
    longint p  = longint'(1) << b[4:0];
    longint r;
    case (op)
      3'd0: r = alt ? ua - ub : ua + ub;
      3'd1: r = ua * p;
      3'd2: r = (sa < sb) ? 1 : 0;
      3'd3: r = (ua < ub) ? 1 : 0;
      3'd4: r = a ^ b;
      3'd5: begin
        if (!alt) r = ua / p;
        else begin
          r = sa / p;
          if (sa < 0 && (sa % p) != 0) r = r - 1;
        end
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r[31:0];
  endfunction

  function automatic logic [31:0] ref_m(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa = $signed(a);
    longint      sb = $signed(b);
    longint      ub = b;
    int          ia = a;
    int          ib = b;
    logic [63:0] p;
    logic        ovf = (a == MinNeg) && (b == 32'hffff_ffff);
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hffff_ffff : ovf ? MinNeg : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic src, input logic [1:0] fwd,
                                       input logic [31:0] alt_v, input logic [31:0] exm,
                                       input logic [31:0] wb, input logic [31:0] reg_v);
    if (src) return alt_v;
    if (fwd == 2'b10) return exm;
    if (fwd == 2'b01) return wb;
    return reg_v;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffff_ffff;
      2: return MinNeg;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_op(input logic is_m, input logic [2:0] op, input logic alt,
                          input logic [31:0] a, input logic [31:0] b);
    bus.i_is_m = is_m;  bus.i_op = op;  bus.i_arith_logic = alt;
    bus.i_op1 = a;  bus.i_op2 = b;
    bus.i_alu_src1 = 1'b0;  bus.i_alu_src2 = 1'b0;
    bus.i_forward_rs1 = 2'b00;  bus.i_forward_rs2 = 2'b00;
    bus.i_pc = $urandom;  bus.i_immediate = $urandom;
    bus.i_ex_mem_res = $urandom;  bus.i_wb_res = $urandom;
    bus.i_valid = 1'b1;
  endtask

  task automatic issue(input logic is_m, input logic [2:0] op, input logic alt,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    drive_op(is_m, op, alt, a, b);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = 1;
    while (!bus.o_valid && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_op(1'b0, 3'd0, 1'b0, 32'd3, 32'd4);
    bus.i_flush = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    n_vec++; if (bus.o_result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.o_result); end
    n_vec++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    rst = 1'b0;  bus.i_valid = 1'b0;  bus.i_flush = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
  endtask

  task automatic test_add_forward();
    @(negedge clk);
    drive_op(1'b0, 3'd0, 1'b0, 32'd99, 32'd7);
    bus.i_forward_rs1 = 2'b10;  bus.i_ex_mem_res = 32'd5;
    @(negedge clk);
    bus.i_valid = 1'b0;
    n_vec++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd12) begin
      n_bad++; $display("FAIL add_fwd: got v=%b %0d want v=1 12", bus.o_valid, bus.o_result);
    end
  endtask

  // Back-to-back ALU issues with random operand routing; one result per cycle.
  task automatic test_alu_random(input int count);
    logic [31:0] exp_q[$];
    logic [31:0] a, b, exp;
    for (int i = 0; i <= count; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = exp_q.pop_front();
        n_vec++; if (bus.o_valid !== 1'b1 || bus.o_result !== exp) begin
          n_bad++; $display("FAIL alu_rand: got v=%b %h want v=1 %h", bus.o_valid, bus.o_result, exp);
        end
        n_vec++; if (bus.o_ready !== 1'b1) begin
          n_bad++; $display("FAIL alu_ready: got %b want 1", bus.o_ready);
        end
      end
      if (i < count) begin
        drive_op(1'b0, 3'($urandom_range(0, 7)), 1'($urandom), $urandom, $urandom);
        bus.i_alu_src1 = 1'($urandom);  bus.i_alu_src2 = 1'($urandom);
        bus.i_forward_rs1 = 2'($urandom);  bus.i_forward_rs2 = 2'($urandom);
        if ($urandom_range(0, 3) == 0) bus.i_op2 = 32'($urandom_range(0, 31));
        a = pick(bus.i_alu_src1, bus.i_forward_rs1, bus.i_pc, bus.i_ex_mem_res, bus.i_wb_res,
                 bus.i_op1);
        b = pick(bus.i_alu_src2, bus.i_forward_rs2, bus.i_immediate, bus.i_ex_mem_res,
                 bus.i_wb_res, bus.i_op2);
        exp_q.push_back(ref_alu(bus.i_op, bus.i_arith_logic, a, b));
      end else begin
        bus.i_valid = 1'b0;
      end
    end
  endtask

  task automatic test_mulh();
    int low_rdy = 0;
    int busy_n  = 0;
    issue(1'b1, 3'd1, 1'b0, MinNeg, MinNeg);
    for (int k = 1; k <= 32; k++) begin
      if (bus.o_ready === 1'b0 && bus.o_valid === 1'b0) low_rdy++;
      if (bus.o_busy === 1'b1) busy_n++;
      @(negedge clk);
    end
    n_vec++; if (low_rdy != 32) begin n_bad++; $display("FAIL mulh_ready_low: got %0d cycles want 32", low_rdy); end
    n_vec++; if (busy_n != 32) begin n_bad++; $display("FAIL mulh_busy: got %0d cycles want 32", busy_n); end
    n_vec++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'h4000_0000) begin
      n_bad++; $display("FAIL mulh_result: got v=%b %h want v=1 40000000", bus.o_valid, bus.o_result);
    end
  endtask

  task automatic test_div_bypass();
    issue(1'b1, 3'd4, 1'b0, MinNeg, 32'hffff_ffff);
    n_vec++; if (bus.o_valid !== 1'b1 || bus.o_result !== MinNeg) begin
      n_bad++; $display("FAIL div_ovf: got v=%b %h want v=1 80000000", bus.o_valid, bus.o_result);
    end
    issue(1'b1, 3'd6, 1'b0, 32'd9, 32'd0);
    n_vec++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd9) begin
      n_bad++; $display("FAIL rem_zero: got v=%b %h want v=1 9", bus.o_valid, bus.o_result);
    end
  endtask

  task automatic test_m_random(input int count);
    logic [31:0] a, b, exp;
    logic [2:0]  op;
    int          lat, exp_lat;
    for (int i = 0; i < count; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = rand_operand();
      b   = rand_operand();
      exp = ref_m(op, a, b);
      exp_lat = (op[2] && (b == 0 || (!op[0] && a == MinNeg && b == 32'hffff_ffff))) ? 1 : NW + 1;
      issue(1'b1, op, 1'b0, a, b);
      wait_valid(NW + 8, lat);
      n_vec++; if (bus.o_valid !== 1'b1 || lat != exp_lat) begin
        n_bad++; $display("FAIL m_latency op=%0d: got v=%b lat=%0d want lat=%0d", op, bus.o_valid, lat, exp_lat);
      end
      n_vec++; if (bus.o_result !== exp) begin
        n_bad++; $display("FAIL m_result op=%0d a=%h b=%h: got %h want %h", op, a, b, bus.o_result, exp);
      end
    end
  endtask

  task automatic test_divu_hold();
    int lat;
    int good = 0;
    issue(1'b1, 3'd5, 1'b0, 32'd100, 32'd7);
    bus.i_ready = 1'b0;
    wait_valid(NW + 8, lat);
    drive_op(1'b0, 3'd0, 1'b0, 32'd1, 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (bus.o_valid === 1'b1 && bus.o_result === 32'd14 && bus.o_ready === 1'b0) good++;
      @(negedge clk);
    end
    n_vec++; if (lat != NW + 1) begin n_bad++; $display("FAIL divu_latency: got %0d want %0d", lat, NW + 1); end
    n_vec++; if (good != 5) begin n_bad++; $display("FAIL divu_hold: got %0d stable cycles want 5", good); end
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    n_vec++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'd2) begin
      n_bad++; $display("FAIL divu_release: got v=%b %h want v=1 2", bus.o_valid, bus.o_result);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    int lat;
    issue(1'b1, 3'd6, 1'b0, 32'hffff_fff9, 32'd2);
    repeat (9) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    n_vec++; if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle: got rdy=%b busy=%b want 1 0", bus.o_ready, bus.o_busy);
    end
    for (int k = 0; k < 40; k++) begin
      if (bus.o_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_vec++; if (seen != 0) begin n_bad++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
    issue(1'b1, 3'd6, 1'b0, 32'hffff_fff9, 32'd2);
    wait_valid(NW + 8, lat);
    n_vec++; if (bus.o_valid !== 1'b1 || bus.o_result !== 32'hffff_ffff) begin
      n_bad++; $display("FAIL rem_reissue: got v=%b %h want v=1 ffffffff", bus.o_valid, bus.o_result);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen = 0;
    issue(1'b1, 3'd0, 1'b0, $urandom, $urandom);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    drive_op(1'b0, 3'd0, 1'b0, 32'd1, 32'd2);
    @(negedge clk);
    n_vec++; if (bus.o_valid !== 1'b0 || bus.o_result !== 32'h0 || bus.o_busy !== 1'b0 ||
                 bus.o_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_mid_mul: got v=%b r=%h busy=%b rdy=%b want 0 0 0 1",
                        bus.o_valid, bus.o_result, bus.o_busy, bus.o_ready);
    end
    rst = 1'b0;  bus.i_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.o_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_vec++; if (seen != 0) begin n_bad++; $display("FAIL reset_no_result: got %0d valid cycles want 0", seen); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b0;  bus.i_flush = 1'b0;  bus.i_ready = 1'b1;
    drive_op(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
    bus.i_valid = 1'b0;
    test_reset();
    test_add_forward();
    test_alu_random(40);
    test_mulh();
    test_div_bypass();
    test_m_random(24);
    test_divu_hold();
    test_flush();
    test_reset_mid_mul();
    test_alu_random(8);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 Parameter NB_WORD, default 32, datapath width in bits; legal values are even and >= 8.
REQ-002 Parameter NB_CNT, default $clog2(NB_WORD)+1, iteration counter width.
REQ-003 i_clock  input  1  single clock; all state updates on the rising edge.
REQ-004 i_reset  input  1  reset, synchronous and active-high.
REQ-005 i_valid  input  1  issue request; accepted when i_valid && o_ready.
REQ-006 o_ready  output 1  unit can accept an issue this cycle.
REQ-007 i_is_m  input  1  1 = RV32M operation, 0 = base ALU operation.
REQ-008 i_op  input  3  funct3: ALU op when i_is_m=0, M op when i_is_m=1.
REQ-009 i_arith_logic  input  1  ALU only: 1 = SUB for op 000, SRA for op 101.
REQ-010 i_alu_src1 / i_alu_src2  input  1 each  1 = select i_pc / i_immediate for op1 / op2.
REQ-011 i_forward_rs1 / i_forward_rs2  input  2 each  forwarding select: 10 = i_ex_mem_res, 01 = i_wb_res, 00 or 11 = register operand.
REQ-012 i_op1, i_op2, i_immediate, i_pc, i_ex_mem_res, i_wb_res  input  NB_WORD each  operand sources.
REQ-013 i_flush  input  1  abort any operation in progress.
REQ-014 o_valid  output 1  o_result holds a valid result.
REQ-015 i_ready  input  1  downstream accepts the result when o_valid && i_ready.
REQ-016 o_result  output NB_WORD  result.
REQ-017 o_busy  output 1  an iterative multiply or divide is in progress.

Function
REQ-018 Operand muxing shall select, in priority order, i_alu_src (pc/imm), then forward 10, then forward 01, then the register operand; operands shall be latched at accept.
REQ-019 The FSM shall have the states IDLE, MUL, DIV and DONE.
REQ-020 IDLE shall have o_ready = !o_valid || i_ready; in every other state o_ready shall be 0.
REQ-021 An accepted ALU op shall compute combinationally and register into o_result with o_valid=1 on the next edge (latency 1).
REQ-022 ALU ops: 000 ADD/SUB, 001 SLL, 010 SLT (signed), 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND; the shift amount shall be op2[$clog2(NB_WORD)-1:0].
REQ-023 M ops 000-011 (MUL, MULH, MULHSU, MULHU) shall enter MUL and run an iterative shift-add for exactly NB_WORD cycles on magnitudes, then apply sign correction.
REQ-024 M ops 100-111 (DIV, DIVU, REM, REMU) shall enter DIV and run a restoring divide for exactly NB_WORD cycles.
REQ-025 MUL shall return the low NB_WORD bits of the 2*NB_WORD product; MULH, MULHSU and MULHU shall return the high NB_WORD bits (signed x signed, signed x unsigned, unsigned x unsigned).
REQ-026 Signed DIV shall round toward zero, and the sign of REM shall follow the dividend.
REQ-027 Divide by zero shall bypass iteration with latency 1: the quotient is all-ones and the remainder is the dividend.
REQ-028 Signed overflow (most-negative / -1) shall bypass iteration with latency 1: the quotient is most-negative and the remainder is 0.
REQ-029 After the last iteration the FSM shall enter DONE, set o_valid=1, and then return to IDLE; iterative latency from the accept edge to o_valid is NB_WORD+1 cycles.
REQ-030 o_valid and o_result shall hold stable until o_valid && i_ready; the entry into IDLE is not gated by that handshake.
REQ-031 A new issue while a result is held shall be accepted only when i_ready=1 in the same cycle (back-to-back at full throughput).
REQ-032 i_flush shall dominate i_valid: it returns the FSM to IDLE and clears o_valid and the counter next edge; no result from the aborted op shall appear.
REQ-033 o_busy shall be 1 exactly in the states MUL and DIV.

Reset
REQ-034 While i_reset=1 at a clock edge: state=IDLE, o_valid=0, o_result=0, o_busy=0, counter=0; o_ready shall read 1 from the first cycle after reset.
REQ-035 Reset asserted mid-iteration shall abort the operation with no o_valid pulse, and reset shall take precedence over i_flush and i_valid.

Verification (NB_WORD=32)
REQ-036 Issue ADD with forward_rs1=10, i_ex_mem_res=5, i_op2=7 -> o_valid the next cycle, o_result=12.
REQ-037 Issue MULH with 0x80000000 x 0x80000000 -> o_ready=0 for 32 cycles, then o_valid with o_result=0x40000000 at accept+33.
REQ-038 Issue DIV 0x80000000 / 0xFFFFFFFF -> latency 1, o_result=0x80000000; REM with divisor 0 and dividend 9 -> o_result=9.
REQ-039 Issue DIVU 100/7 and hold i_ready=0 for 5 cycles after o_valid -> o_result=14 held stable, and no accept occurs until i_ready=1.
REQ-040 Issue REM -7/2, then assert i_flush at iteration 10 -> no o_valid, o_ready=1 next cycle; re-issue -> o_result=0xFFFFFFFF (-1).
REQ-041 Assert i_reset mid-MUL -> all outputs at reset values next cycle; then ADD back-to-back with i_ready=1 -> one result per cycle.
